// File: rtl/tlb_pkg.sv
// Shared sizes and FSM state encodings for the TLB refill controller.
package tlb_pkg;

  localparam int unsigned NUM_WAYS = 32;
  localparam int unsigned WAY_W    = 5;
  localparam int unsigned VPN_W    = 27;
  localparam int unsigned PPN_W    = 44;
  localparam int unsigned PERM_W   = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4,
    StDrain = 3'd5
  } tlb_state_e;

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// Bundle of miss, page-walk, TLB-write and completion signals around the refill controller.
interface tlb_refill_ctrl_if;
  import tlb_pkg::*;

  logic                flush;
  logic                miss_valid;
  logic [VPN_W-1:0]    miss_vpn;
  logic                miss_ready;
  logic                ptw_req_valid;
  logic [VPN_W-1:0]    ptw_req_vpn;
  logic                ptw_req_ready;
  logic                ptw_resp_valid;
  logic [PPN_W-1:0]    ptw_resp_ppn;
  logic [PERM_W-1:0]   ptw_resp_perm;
  logic                ptw_resp_fault;
  logic [NUM_WAYS-1:0] entry_valid;
  logic [WAY_W-1:0]    lru_way;
  logic                wr_en;
  logic [WAY_W-1:0]    wr_way;
  logic [VPN_W-1:0]    wr_vpn;
  logic [PPN_W-1:0]    wr_ppn;
  logic [PERM_W-1:0]   wr_perm;
  logic                plru_write_access;
  logic [WAY_W-1:0]    plru_write_way;
  logic                done_valid;
  logic                done_fault;

  // Controller side
  modport master (
    input  flush, miss_valid, miss_vpn, ptw_req_ready,
    input  ptw_resp_valid, ptw_resp_ppn, ptw_resp_perm, ptw_resp_fault,
    input  entry_valid, lru_way,
    output miss_ready, ptw_req_valid, ptw_req_vpn,
    output wr_en, wr_way, wr_vpn, wr_ppn, wr_perm,
    output plru_write_access, plru_write_way, done_valid, done_fault
  );

  // Surrounding TLB / walker side
  modport slave (
    output flush, miss_valid, miss_vpn, ptw_req_ready,
    output ptw_resp_valid, ptw_resp_ppn, ptw_resp_perm, ptw_resp_fault,
    output entry_valid, lru_way,
    input  miss_ready, ptw_req_valid, ptw_req_vpn,
    input  wr_en, wr_way, wr_vpn, wr_ppn, wr_perm,
    input  plru_write_access, plru_write_way, done_valid, done_fault
  );

endinterface

// File: rtl/tlb_free_way_enc.sv
// Lowest-index invalid entry finder: returns the first way whose valid bit is 0.
module tlb_free_way_enc
  import tlb_pkg::*;
(
  input  logic [NUM_WAYS-1:0] i_entry_valid,
  output logic [WAY_W-1:0]    o_way,
  output logic                o_found
);

  // Scan from the top down so the lowest clear bit is the last one written
  always_comb begin
    o_way   = '0;
    o_found = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!i_entry_valid[i]) begin
        o_way   = WAY_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller: accepts one miss, requests a page walk, writes the
// result into a free (or PLRU victim) way and pulses completion.
module tlb_refill_ctrl
  import tlb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  tlb_refill_ctrl_if.master io_bus
);

  tlb_state_e        r_state;
  tlb_state_e        w_state_next;
  logic [VPN_W-1:0]  r_vpn;
  logic [PPN_W-1:0]  r_ppn;
  logic [PERM_W-1:0] r_perm;
  logic              r_fault;
  logic [WAY_W-1:0]  r_way;

  logic              w_latch_vpn;
  logic              w_latch_resp;
  logic              w_latch_way;
  logic [WAY_W-1:0]  w_free_way;
  logic              w_free_found;

  tlb_free_way_enc u_free_way_enc (
    .i_entry_valid (io_bus.entry_valid),
    .o_way         (w_free_way),
    .o_found       (w_free_found)
  );

  // State and latched transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_vpn   <= '0;
      r_ppn   <= '0;
      r_perm  <= '0;
      r_fault <= 1'b0;
      r_way   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch_vpn) begin
        r_vpn <= io_bus.miss_vpn;
      end
      if (w_latch_resp) begin
        r_ppn   <= io_bus.ptw_resp_ppn;
        r_perm  <= io_bus.ptw_resp_perm;
        r_fault <= io_bus.ptw_resp_fault;
      end
      if (w_latch_way) begin
        r_way <= w_free_found ? w_free_way : io_bus.lru_way;
      end
    end
  end

  // Next-state and latch-enable decode
  always_comb begin
    w_state_next = r_state;
    w_latch_vpn  = 1'b0;
    w_latch_resp = 1'b0;
    w_latch_way  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.miss_valid && !io_bus.flush) begin
          w_latch_vpn  = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq: begin
        // A request already handed to the walker must have its response drained
        if (io_bus.ptw_req_ready) begin
          w_state_next = io_bus.flush ? StDrain : StWait;
        end else if (io_bus.flush) begin
          w_state_next = StIdle;
        end
      end
      StWait: begin
        if (io_bus.ptw_resp_valid) begin
          if (io_bus.flush) begin
            w_state_next = StIdle;
          end else begin
            w_latch_resp = 1'b1;
            w_latch_way  = !io_bus.ptw_resp_fault;
            w_state_next = io_bus.ptw_resp_fault ? StDone : StWrite;
          end
        end else if (io_bus.flush) begin
          w_state_next = StDrain;
        end
      end
      // Flush is ignored once the write is committed
      StWrite: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      StDrain: begin
        if (io_bus.ptw_resp_valid) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Strobes decode straight from the state register; data comes from latched registers
  assign io_bus.miss_ready        = (r_state == StIdle);
  assign io_bus.ptw_req_valid     = (r_state == StReq);
  assign io_bus.ptw_req_vpn       = r_vpn;
  assign io_bus.wr_en             = (r_state == StWrite);
  assign io_bus.wr_way            = r_way;
  assign io_bus.wr_vpn            = r_vpn;
  assign io_bus.wr_ppn            = r_ppn;
  assign io_bus.wr_perm           = r_perm;
  assign io_bus.plru_write_access = (r_state == StWrite);
  assign io_bus.plru_write_way    = r_way;
  assign io_bus.done_valid        = (r_state == StDone);
  assign io_bus.done_fault        = (r_state == StDone) && r_fault;

endmodule

// File: doc/tlb_refill_ctrl.md
TLB_REFILL_CTRL -- requirements
Module: tlb_refill_ctrl

Interface
REQ-001 Parameters: NUM_WAYS = 32 (entry count); WAY_W = 5 (way index width); VPN_W = 27 (Sv39 VPN); PPN_W = 44; PERM_W = 8.
REQ-002 Reset is rst, synchronous, active-high; clock is clk. All state changes on the rising edge of clk.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  sync active-high reset
  flush  in  1  abort the refill in progress; no TLB write results
  miss_valid  in  1  lookup miss present
  miss_vpn  in  VPN_W  missing VPN
  miss_ready  out  1  controller accepts the miss (high only in IDLE)
  ptw_req_valid  out  1  page-walk request
  ptw_req_vpn  out  VPN_W  VPN to walk
  ptw_req_ready  in  1  walker accepts the request
  ptw_resp_valid  in  1  walk result; one cycle; no back-pressure
  ptw_resp_ppn  in  PPN_W  translated PPN
  ptw_resp_perm  in  PERM_W  permission/attribute bits
  ptw_resp_fault  in  1  walk faulted
  entry_valid  in  NUM_WAYS  current valid bit of each TLB entry
  lru_way  in  WAY_W  victim way from the TLB PLRU
  wr_en  out  1  TLB entry write strobe
  wr_way  out  WAY_W  way to write
  wr_vpn / wr_ppn / wr_perm  out  VPN_W / PPN_W / PERM_W  entry contents
  plru_write_access  out  1  to PLRU WriteAccess; equal to wr_en
  plru_write_way  out  WAY_W  to PLRU WriteWay; equal to wr_way
  done_valid  out  1  one-cycle refill-complete pulse
  done_fault  out  1  qualifies done_valid: walk faulted

Function
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT, WRITE, DONE and DRAIN, encoded in a 3-bit register.
REQ-005 IDLE: miss_ready=1; on miss_valid&&!flush, latch miss_vpn and go to REQ.
REQ-006 REQ: ptw_req_valid=1 and ptw_req_vpn=latched VPN, held stable until ptw_req_ready; on the handshake go to WAIT.
REQ-007 WAIT: on ptw_resp_valid, latch ppn, perm and fault; go to DONE if fault=1, otherwise go to WRITE.
REQ-008 Victim is sampled at the WAIT->WRITE transition: the lowest-index way with entry_valid=0, else lru_way.
REQ-009 WRITE lasts exactly 1 cycle: wr_en=plru_write_access=1, with wr_way=plru_write_way=victim and the latched VPN/PPN/perm on the data outputs; then go to DONE.
REQ-010 DONE lasts 1 cycle: done_valid=1 and done_fault=latched fault; then go to IDLE.
REQ-011 Latency from response to done: 2 cycles without a fault, 1 cycle with a fault. From miss accept to ptw_req_valid: 1 cycle.
REQ-012 flush in REQ: drop ptw_req_valid in the next cycle and go to IDLE (the request was never accepted).
REQ-013 flush on the same cycle as the REQ handshake: go to DRAIN.
REQ-014 flush in WAIT: go to DRAIN.
REQ-015 flush coincident with ptw_resp_valid in WAIT: go to IDLE with no write and no done.
REQ-016 DRAIN: wait for ptw_resp_valid, discard the response, go to IDLE; no wr_en and no done_valid.
REQ-017 flush in WRITE or DONE: no effect; the entry is still written and done still pulses.
REQ-018 At most one refill is outstanding; miss_ready=0 in every state other than IDLE.
REQ-019 wr_en, plru_write_access, done_valid and ptw_req_valid SHALL be registered-state decodes, glitch-free and free of any combinational path from any input.

Reset
REQ-020 rst SHALL force the state to IDLE and all latched registers to 0.
REQ-021 After reset, every output is 0 except miss_ready, which is 1.
REQ-022 rst mid-refill abandons the walk with no write; the walker is reset by the same rst.

Structure
REQ-023 A shared package (tlb_pkg) SHALL hold NUM_WAYS, WAY_W, VPN_W, PPN_W, PERM_W and the FSM state encodings.
REQ-024 One sub-module, tlb_free_way_enc, SHALL be a combinational NUM_WAYS-to-WAY_W lowest-zero priority encoder with a found flag.
REQ-025 The PLRU itself is instantiated outside this block; the controller only drives WriteAccess/WriteWay into it.

Verification
REQ-026 Reset, then idle: miss_ready=1; all other outputs 0 for 10 cycles.
REQ-027 Miss on VPN 0x12345 with entry_valid=0xFFFF_FFF7; response PPN 0xABC, perm 0xCF after 5 cycles -> wr_way=3, wr_ppn=0xABC, wr_perm=0xCF; done_valid=1 with done_fault=0 exactly 2 cycles after the response.
REQ-028 entry_valid=0xFFFF_FFFF and lru_way=17 -> wr_way=17 and plru_write_way=17 in a single-cycle write.
REQ-029 ptw_req_ready held low 4 cycles -> ptw_req_valid and ptw_req_vpn stay stable; handshake happens on cycle 5.
REQ-030 Response with fault=1 -> no wr_en; done_valid=1 with done_fault=1 one cycle later.
REQ-031 flush 2 cycles into WAIT, response 3 cycles later -> no wr_en and no done_valid; miss_ready=1 the cycle after the response; a new miss is then accepted normally.
